// File: rtl/vend_ctrl_n.sv
// Parametrised vending controller: coin edge detect, bounded credit, lowest-index
// item arbitration, and greedy one-coin-per-cycle change/refund sequencing.
module vend_ctrl_n #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 7,
    parameter int CREDIT_MAX = 95,
    parameter int PRICE_BASE = 35,
    parameter int PRICE_STEP = 15
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Quarters,
    input  logic                 Dimes,
    input  logic                 Nickles,
    input  logic [NUM_ITEMS-1:0] Buy,
    input  logic                 Refund,
    output logic [CREDIT_W-1:0]  Credit,
    output logic [NUM_ITEMS-1:0] Vending,
    output logic                 CoinReject,
    output logic                 QuarterOut,
    output logic                 DimeOut,
    output logic                 NickelOut,
    output logic                 Busy
);

    // state     | meaning
    // ST_IDLE   | accepting coins, buy and refund requests
    // ST_VEND   | one cycle, Vending pulse on selected item
    // ST_CHANGE | returning credit one coin per cycle, largest coin first
    typedef enum logic [1:0] {ST_IDLE, ST_VEND, ST_CHANGE} state_t;

    localparam int XW = CREDIT_W + 1;
    localparam logic [XW-1:0] CMAX_X = XW'(CREDIT_MAX);

    state_t state, next_state;

    logic q_prev, d_prev, n_prev;
    logic q_edge, d_edge, n_edge, coin_any;
    logic [XW-1:0] add_x, sum_x, credit_x;

    logic [CREDIT_W-1:0]  price_tab [NUM_ITEMS];
    logic [CREDIT_W-1:0]  sel_price;
    logic [NUM_ITEMS-1:0] sel_onehot;
    logic                 buy_any;

    logic [CREDIT_W-1:0]  next_credit;
    logic [NUM_ITEMS-1:0] next_vending;
    logic next_reject, next_q, next_d, next_n;

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
        assign price_tab[i] = CREDIT_W'(PRICE_BASE + i * PRICE_STEP);
    end

    assign q_edge   = Quarters & ~q_prev;
    assign d_edge   = Dimes & ~d_prev;
    assign n_edge   = Nickles & ~n_prev;
    assign coin_any = q_edge | d_edge | n_edge;

    // Extra bit on the add path keeps Credit+25 from wrapping before the limit check.
    assign add_x    = (q_edge ? XW'(25) : '0) + (d_edge ? XW'(10) : '0) + (n_edge ? XW'(5) : '0);
    assign credit_x = {1'b0, Credit};
    assign sum_x    = credit_x + add_x;

    always_comb begin
        sel_onehot = '0;
        sel_price  = '0;
        buy_any    = 1'b0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (Buy[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_price     = price_tab[i];
                buy_any       = 1'b1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_credit  = Credit;
        next_vending = '0;
        next_reject  = 1'b0;
        next_q       = 1'b0;
        next_d       = 1'b0;
        next_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buy_any && (Credit >= sel_price)) begin
                    next_state   = ST_VEND;
                    next_credit  = Credit - sel_price;
                    next_vending = sel_onehot;
                    next_reject  = coin_any;
                end else begin
                    if (sum_x <= CMAX_X) next_credit = sum_x[CREDIT_W-1:0];
                    else                 next_reject = 1'b1;
                    if (Refund && (Credit != '0)) next_state = ST_CHANGE;
                end
            end
            ST_VEND: begin
                next_reject = coin_any;
                next_state  = (Credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                next_reject = coin_any;
                if (credit_x >= XW'(25)) begin
                    next_q      = 1'b1;
                    next_credit = Credit - CREDIT_W'(25);
                end else if (credit_x >= XW'(10)) begin
                    next_d      = 1'b1;
                    next_credit = Credit - CREDIT_W'(10);
                end else if (credit_x >= XW'(5)) begin
                    next_n      = 1'b1;
                    next_credit = Credit - CREDIT_W'(5);
                end
                if (next_credit == '0) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        // History follows the levels even in reset so a held slot is never counted.
        q_prev <= Quarters;
        d_prev <= Dimes;
        n_prev <= Nickles;
        if (Reset) begin
            state      <= ST_IDLE;
            Credit     <= '0;
            Vending    <= '0;
            CoinReject <= 1'b0;
            QuarterOut <= 1'b0;
            DimeOut    <= 1'b0;
            NickelOut  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= next_state;
            Credit     <= next_credit;
            Vending    <= next_vending;
            CoinReject <= next_reject;
            QuarterOut <= next_q;
            DimeOut    <= next_d;
            NickelOut  <= next_n;
            Busy       <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: doc/vend_ctrl_n.md
Name: vend_ctrl_n

Overview:
- Parametrised, single-clock vending controller; successor to the fixed 4-item coin/buy/refund datapath.
- Synchronously edge-detects coin inputs and holds a bounded credit register.
- Arbitrates among N items with per-item computed prices.
- Returns change or refunds as a sequence of one-coin-per-cycle pulses under an explicit FSM.
- Sits between the coin/button front end and the seven-segment/coin-count display logic.

Parameters:
- NUM_ITEMS, 4, number of selectable items (1..16)
- CREDIT_W, 7, width of the credit register and of the Credit port
- CREDIT_MAX, 95, maximum credit in cents; must be a multiple of 5 and < 2**CREDIT_W
- PRICE_BASE, 35, price of item 0 in cents; multiple of 5
- PRICE_STEP, 15, price increment per item index; price(i) = PRICE_BASE + i*PRICE_STEP; every price must be ≤ CREDIT_MAX

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  synchronous, active-high; clears all state
- Quarters  in  1  coin-slot level, synchronous to Clock; one rising edge = one 25c coin
- Dimes  in  1  coin-slot level; one rising edge = one 10c coin
- Nickles  in  1  coin-slot level; one rising edge = one 5c coin
- Buy  in  NUM_ITEMS  item request levels; sampled every cycle
- Refund  in  1  refund request level
- Credit  out  CREDIT_W  current credit in cents, registered
- Vending  out  NUM_ITEMS  one-cycle pulse on the bit of the dispensed item
- CoinReject  out  1  one-cycle pulse; coin(s) on this edge not credited
- QuarterOut  out  1  one-cycle pulse = one 25c coin returned
- DimeOut  out  1  one-cycle pulse = one 10c coin returned
- NickelOut  out  1  one-cycle pulse = one 5c coin returned
- Busy  out  1  high while in VEND or CHANGE

Behaviour:
- Reset, checked at a Clock edge:
  - Credit=0, Vending=0, CoinReject=0, QuarterOut/DimeOut/NickelOut=0, Busy=0.
  - Coin edge-detect history is loaded with the current input levels, so a slot held high through reset is not counted.
  - State=IDLE.
  - Reset overrides every other input in any state, including mid-CHANGE; undelivered change is discarded.
- Edge detect: coin_edge = level & ~prev_level; prev_level is registered every cycle in all states.
- All outputs are registered. A coin edge sampled at edge k shows on Credit after edge k (1-cycle latency). Vending, coin-out and CoinReject pulses each last exactly one cycle.
- IDLE, coin handling:
  - add = 25*Q_edge + 10*D_edge + 5*N_edge; simultaneous edges are summed.
  - If Credit+add ≤ CREDIT_MAX: Credit += add.
  - Otherwise all coins of that cycle are rejected: CoinReject=1, Credit unchanged.
- IDLE, buy handling:
  - Selected item = lowest asserted Buy index.
  - If Credit ≥ price(sel): go to VEND and Credit -= price(sel). Coins arriving on that same edge are rejected (CoinReject=1).
  - If Credit < price(sel): request ignored, no state change, coins handled normally.
- IDLE, refund: Refund=1 with Credit>0 and no successful buy → CHANGE. Buy has priority over Refund on the same edge. Refund with Credit=0 is ignored.
- VEND (1 cycle): Vending[sel]=1 → CHANGE if Credit>0, else IDLE.
- CHANGE, one coin per cycle, greedy:
  - Credit ≥ 25: QuarterOut, Credit -= 25.
  - Else Credit ≥ 10: DimeOut, Credit -= 10.
  - Else Credit ≥ 5: NickelOut, Credit -= 5.
  - When Credit reaches 0, the next state is IDLE.
- In VEND and CHANGE: Buy and Refund are ignored; every coin edge gives CoinReject=1 and is not credited.
- Busy = (state != IDLE), registered alongside state.
- Width rules:
  - Prices are computed at elaboration at CREDIT_W bits.
  - The add and compare path is CREDIT_W+1 bits wide so Credit+25 cannot wrap.
  - Credit never exceeds CREDIT_MAX and never goes below 0.
- A coin level held high counts once; a second coin needs a low cycle first.

Test Plan:
- Reset with Quarters held high, then release and re-raise Quarters → Credit=0 after reset, then 25 one cycle after the re-raise; no count during the held level.
- Insert Q,Q,D (70c), then Buy=4'b0010 (price 50) → Vending=4'b0010 for 1 cycle, then DimeOut, DimeOut pulses on consecutive cycles, Credit 20→10→0, Busy low after.
- Raise Buy=4'b1100 with 85c → item 2 (65c) vends; change = DimeOut, DimeOut; Credit 0.
- Credit 80, then Quarters edge → CoinReject pulse, Credit stays 80. Then raise Dimes and Nickles on the same cycle with credit 80 → Credit 95.
- Refund at 45c → QuarterOut, DimeOut, DimeOut on 3 consecutive cycles. A coin inserted mid-sequence gives CoinReject and Credit is not increased. Refund at 0c → no response.
- Buy and Refund on the same edge with 60c, item 0 → Vending[0], then change of 25 as one QuarterOut. Separately, assert Reset mid-CHANGE → all outputs 0 next cycle, state IDLE.
